haze_frame_ctrl: RTL and testbench
==================================

HAZE_FRAME_CTRL -- requirements
Module: haze_frame_ctrl

Interface
REQ-001 SHALL have parameter PIC_WIDTH, default 640, meaning active pixels per line.
REQ-002 SHALL have parameter PIC_HEIGHT, default 480, meaning active lines per frame.
REQ-003 SHALL have parameter WARMUP_FRAMES, default 1, meaning the number of completed frames with forced bypass after reset.
REQ-004 SHALL have parameter ATM_TIMEOUT, default 1024, meaning the maximum number of cycles to wait for atm_valid after frame end.
REQ-005 SHALL have parameter ATM_DEFAULT, default 24'hF0F0F0, meaning the atmospheric light used after reset.
REQ-006 SHALL have ports: clk input 1 system clock; rst input 1 reset, synchronous, active-high.
REQ-007 SHALL have ports: pre_frame_vsync, pre_frame_href and pre_frame_clken, each input 1, the incoming video timing (vsync high = frame active).
REQ-008 SHALL have ports: cfg_wr input 1 write strobe; cfg_addr input 2 register select; cfg_wdata input 8 write data.
REQ-009 SHALL have ports: atm_valid input 1 and atm_light input 24 {R,G,B}, the datapath's atmospheric-light estimate for the frame just ended.
REQ-010 SHALL have ports: proc_bypass output 1; proc_omega output 8; proc_t0 output 8; proc_atm output 24, the active datapath configuration.
REQ-011 SHALL have ports: frame_start output 1 pulse; frame_done output 1 pulse; geom_err output 1; frame_cnt output 16.

Function
REQ-012 FSM SHALL have states IDLE, ACTIVE, CHECK and UPDATE; vsync and href edges SHALL be detected against 1-cycle registered copies.
REQ-013 IDLE -> ACTIVE on the vsync rising edge; shadow registers SHALL be copied to proc_bypass/omega/t0, and frame_start SHALL pulse, on the cycle after the edge.
REQ-014 ACTIVE: pixel counter SHALL increment on href&&clken; on the href falling edge it SHALL compare to PIC_WIDTH (mismatch sets the frame error flag), increment the line counter and clear.
REQ-015 ACTIVE -> CHECK on the vsync falling edge; CHECK (1 cycle) SHALL compare lines to PIC_HEIGHT, update geom_err, pulse frame_done, increment frame_cnt (saturating at 16'hFFFF) and go to UPDATE.
REQ-016 UPDATE SHALL latch proc_atm from atm_light on atm_valid and go to IDLE; after ATM_TIMEOUT cycles without atm_valid it SHALL go to IDLE with proc_atm unchanged.
REQ-017 A vsync rising edge in UPDATE SHALL abandon the wait, keep proc_atm, and enter ACTIVE exactly as in REQ-013; atm_valid in the same cycle SHALL be ignored.
REQ-018 atm_valid outside UPDATE SHALL be ignored.
REQ-019 Config writes SHALL go to shadow registers in any state: addr0 bit0 = bypass, addr1 = omega, addr2 = t0, addr3 ignored.
REQ-020 A write coincident with the frame-start copy SHALL take effect at the next frame only.
REQ-021 proc_bypass SHALL equal shadow bypass OR (frame_cnt < WARMUP_FRAMES), evaluated at the copy.
REQ-022 geom_err SHALL hold its value from frame_done until the next frame_done.
REQ-023 href activity in IDLE, CHECK or UPDATE SHALL NOT affect the counters.

Reset
REQ-024 On rst: state IDLE, counters 0, frame_cnt 0, geom_err 0, frame_start/frame_done 0.
REQ-025 On rst: proc_bypass 1, proc_omega 8'd243, proc_t0 8'd26, proc_atm ATM_DEFAULT; shadows SHALL take the same values, with shadow bypass 0.
REQ-026 rst asserted mid-frame SHALL abort the frame with no frame_done; after release, the controller SHALL wait for a fresh vsync rising edge (vsync already high SHALL NOT start a frame).

Configuration
REQ-027 With HAZE_ATM_IIR_EN defined, each 8-bit channel of proc_atm SHALL update to (3*old + new) >> 2, using a 10-bit intermediate and truncation.
REQ-028 Without HAZE_ATM_IIR_EN, proc_atm SHALL be replaced directly by atm_light.

Structure
REQ-029 A shared package haze_pkg SHALL hold the FSM state enum, the register addresses, and the reset constants for omega and t0.
REQ-030 A sub-module haze_atm_iir SHALL implement the per-channel update of REQ-027/028; the FSM and counters SHALL stay in the top module.

Verification
REQ-031 The bench SHALL cover: PIC_WIDTH=8, PIC_HEIGHT=4, two clean frames -> frame_start one cycle after each vsync rise, frame_done one cycle after each fall, geom_err=0, frame_cnt=2, proc_bypass 1 on frame 1 and 0 on frame 2.
REQ-032 The bench SHALL cover: line 2 carries 7 pixels -> geom_err=1 at frame_done; the next clean frame -> geom_err=0.
REQ-033 The bench SHALL cover: a write of addr1=8'h80 mid-frame -> proc_omega unchanged until the next frame_start, then 8'h80.
REQ-034 The bench SHALL cover: atm_light=24'h404040 with atm_valid 5 cycles after frame end -> proc_atm=24'h404040 without the macro and 24'hC4C4C4 with it (from ATM_DEFAULT).
REQ-035 The bench SHALL cover: no atm_valid for ATM_TIMEOUT cycles -> return to IDLE with proc_atm unchanged; vsync rise during UPDATE -> immediate ACTIVE and frame_start.
REQ-036 The bench SHALL cover: rst mid-frame with vsync held high -> no frame_done and no frame_start until vsync falls and rises again.

Source files
------------

// File: rtl/haze_pkg.sv
`default_nettype none
// ============================================================================
// Module      : haze_pkg
// Description : Shared types and constants for the haze frame controller.
//               Holds the controller state encoding, the configuration
//               register map and the reset values of the strength (omega)
//               and transmission floor (t0) controls.
// Revision    : 1.0 - initial release
// ============================================================================
package haze_pkg;

    // Controller states, explicit 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_UPDATE = 2'd3
    } haze_state_t;

    // Configuration register map (address 3 is reserved and ignored)
    localparam logic [1:0] c_addr_bypass = 2'd0;
    localparam logic [1:0] c_addr_omega  = 2'd1;
    localparam logic [1:0] c_addr_t0     = 2'd2;

    // Power-up values of the datapath controls
    localparam logic [7:0] c_omega_rst = 8'd243;
    localparam logic [7:0] c_t0_rst    = 8'd26;

endpackage : haze_pkg
`default_nettype wire

// File: rtl/haze_atm_iir.sv
`default_nettype none
// ============================================================================
// Module      : haze_atm_iir
// Description : Next value of the atmospheric light register, per 8-bit
//               channel {R,G,B}. Combinational; the caller owns the register.
//               Build option HAZE_ATM_IIR_EN:
//                 defined   -> next = (3*old + new) >> 2 per channel
//                              (10-bit intermediate, truncating)
//                 undefined -> next = new
// Ports       : i_atm_old  [23:0] current atmospheric light
//               i_atm_new  [23:0] estimate for the frame just ended
//               o_atm_next [23:0] value to load
// Revision    : 1.0 - initial release
// ============================================================================
module haze_atm_iir (
    input  logic [23:0] i_atm_old,
    input  logic [23:0] i_atm_new,
    output logic [23:0] o_atm_next
);

    for (genvar g = 0; g < 3; g++) begin : g_chan
`ifdef HAZE_ATM_IIR_EN
        // 3*255 + 255 = 1020 fits in 10 bits; >>2 is a plain truncation
        logic [9:0] w_acc;
        logic       w_unused_lsb;
        assign w_acc = (10'd3 * {2'b00, i_atm_old[g*8 +: 8]})
                     + {2'b00, i_atm_new[g*8 +: 8]};
        assign o_atm_next[g*8 +: 8] = w_acc[9:2];
        assign w_unused_lsb = ^w_acc[1:0];
`else
        assign o_atm_next[g*8 +: 8] = i_atm_new[g*8 +: 8];
`endif
    end

`ifndef HAZE_ATM_IIR_EN
    // Direct replacement does not look at the previous value
    logic w_unused_old;
    assign w_unused_old = ^i_atm_old;
`endif

endmodule : haze_atm_iir
`default_nettype wire

// File: rtl/haze_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : haze_frame_ctrl
// Description : Frame-level controller for the dehaze datapath. Tracks video
//               frames from vsync/href/clken, checks frame geometry, double-
//               buffers the datapath configuration at frame start and
//               captures the per-frame atmospheric light estimate.
//               Build option HAZE_ATM_IIR_EN selects IIR smoothing of the
//               atmospheric light (see haze_atm_iir).
// Ports       : clk, rst                 clock, synchronous active-high reset
//               pre_frame_vsync/href/clken incoming video timing
//               cfg_wr, cfg_addr, cfg_wdata shadow register write port
//               atm_valid, atm_light      atmospheric light estimate {R,G,B}
//               proc_bypass/omega/t0/atm  active datapath configuration
//               frame_start, frame_done   one-cycle frame event pulses
//               geom_err                  last completed frame had bad geometry
//               frame_cnt                 completed frames (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
module haze_frame_ctrl
    import haze_pkg::*;
#(
    parameter int          PIC_WIDTH     = 640,
    parameter int          PIC_HEIGHT    = 480,
    parameter int          WARMUP_FRAMES = 1,
    parameter int          ATM_TIMEOUT   = 1024,
    parameter logic [23:0] ATM_DEFAULT   = 24'hF0F0F0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pre_frame_vsync,
    input  logic        pre_frame_href,
    input  logic        pre_frame_clken,
    input  logic        cfg_wr,
    input  logic [1:0]  cfg_addr,
    input  logic [7:0]  cfg_wdata,
    input  logic        atm_valid,
    input  logic [23:0] atm_light,
    output logic        proc_bypass,
    output logic [7:0]  proc_omega,
    output logic [7:0]  proc_t0,
    output logic [23:0] proc_atm,
    output logic        frame_start,
    output logic        frame_done,
    output logic        geom_err,
    output logic [15:0] frame_cnt
);

    localparam logic [15:0] c_width   = 16'(PIC_WIDTH);
    localparam logic [15:0] c_height  = 16'(PIC_HEIGHT);
    localparam logic [31:0] c_to_last = 32'(ATM_TIMEOUT - 1);

    haze_state_t r_state;
    logic        r_vsync_d;
    logic        r_href_d;
    logic [15:0] r_pix_cnt;
    logic [15:0] r_line_cnt;
    logic        r_frame_err;
    logic [31:0] r_to_cnt;
    logic        r_sh_bypass;
    logic [7:0]  r_sh_omega;
    logic [7:0]  r_sh_t0;

    logic        w_vsync_rise;
    logic        w_vsync_fall;
    logic        w_href_fall;
    logic        w_frame_begin;
    logic        w_warmup;
    logic [15:0] w_pix_next;
    logic [15:0] w_line_next;
    logic        w_err_next;
    logic [23:0] w_atm_next;

    assign w_vsync_rise = pre_frame_vsync & ~r_vsync_d;
    assign w_vsync_fall = ~pre_frame_vsync & r_vsync_d;
    assign w_href_fall  = ~pre_frame_href & r_href_d;

    // A new frame may begin from IDLE or by abandoning the atm wait
    assign w_frame_begin = w_vsync_rise &&
                           ((r_state == ST_IDLE) || (r_state == ST_UPDATE));

    assign w_warmup = ({16'd0, frame_cnt} < 32'(WARMUP_FRAMES));

    // Line bookkeeping for this cycle; only committed while ACTIVE. The
    // frame-end check uses these so a line closing on the same cycle as
    // vsync falling is still counted.
    always_comb begin
        w_pix_next  = r_pix_cnt;
        w_line_next = r_line_cnt;
        w_err_next  = r_frame_err;
        if (w_href_fall) begin
            w_pix_next  = '0;
            w_line_next = (r_line_cnt == 16'hFFFF) ? r_line_cnt : r_line_cnt + 16'd1;
            if (r_pix_cnt != c_width) begin
                w_err_next = 1'b1;
            end
        end else if (pre_frame_href && pre_frame_clken) begin
            w_pix_next = (r_pix_cnt == 16'hFFFF) ? r_pix_cnt : r_pix_cnt + 16'd1;
        end
    end

    haze_atm_iir u_atm_iir (
        .i_atm_old  (proc_atm),
        .i_atm_new  (atm_light),
        .o_atm_next (w_atm_next)
    );

    // Outputs are registered on entry to a state, so frame_start is high in
    // the first ACTIVE cycle and frame_done / geom_err / frame_cnt present
    // the frame check during the single CHECK cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            // Seeded high so a vsync already high at release is not an edge
            r_vsync_d   <= 1'b1;
            r_href_d    <= 1'b0;
            r_pix_cnt   <= '0;
            r_line_cnt  <= '0;
            r_frame_err <= 1'b0;
            r_to_cnt    <= '0;
            r_sh_bypass <= 1'b0;
            r_sh_omega  <= c_omega_rst;
            r_sh_t0     <= c_t0_rst;
            proc_bypass <= 1'b1;
            proc_omega  <= c_omega_rst;
            proc_t0     <= c_t0_rst;
            proc_atm    <= ATM_DEFAULT;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            geom_err    <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            r_vsync_d   <= pre_frame_vsync;
            r_href_d    <= pre_frame_href;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;

            // Shadow writes; a write on the copy cycle lands after the copy
            if (cfg_wr) begin
                case (cfg_addr)
                    c_addr_bypass: r_sh_bypass <= cfg_wdata[0];
                    c_addr_omega:  r_sh_omega  <= cfg_wdata;
                    c_addr_t0:     r_sh_t0     <= cfg_wdata;
                    default:       ;
                endcase
            end

            if (w_frame_begin) begin
                r_state     <= ST_ACTIVE;
                frame_start <= 1'b1;
                proc_bypass <= r_sh_bypass | w_warmup;
                proc_omega  <= r_sh_omega;
                proc_t0     <= r_sh_t0;
                r_pix_cnt   <= '0;
                r_line_cnt  <= '0;
                r_frame_err <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: ;
                    ST_ACTIVE: begin
                        if (w_vsync_fall) begin
                            r_state    <= ST_CHECK;
                            frame_done <= 1'b1;
                            geom_err   <= w_err_next || (w_line_next != c_height);
                            frame_cnt  <= (frame_cnt == 16'hFFFF) ? frame_cnt
                                                                  : frame_cnt + 16'd1;
                            r_pix_cnt  <= '0;
                            r_line_cnt <= '0;
                        end else begin
                            r_pix_cnt   <= w_pix_next;
                            r_line_cnt  <= w_line_next;
                            r_frame_err <= w_err_next;
                        end
                    end
                    ST_CHECK: begin
                        r_state  <= ST_UPDATE;
                        r_to_cnt <= '0;
                    end
                    ST_UPDATE: begin
                        if (atm_valid) begin
                            proc_atm <= w_atm_next;
                            r_state  <= ST_IDLE;
                        end else if (r_to_cnt == c_to_last) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_to_cnt <= r_to_cnt + 32'd1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule : haze_frame_ctrl
`default_nettype wire

// File: tb/tb_haze_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_haze_frame_ctrl
// Description : Self-checking bench for haze_frame_ctrl. Stimulus tasks
//               describe whole frames/lines and record what the outputs must
//               become and on which cycle; a per-cycle checker compares the
//               DUT against that frame-level model, and literal checks pin
//               key values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_haze_frame_ctrl;

    localparam int          W      = 8;
    localparam int          H      = 4;
    localparam int          WARMUP = 1;
    localparam int          ATM_T  = 16;
    localparam logic [23:0] ATM_D  = 24'hF0F0F0;

    logic        clk = 1'b0;
    logic        rst;
    logic        vsync, href, clken;
    logic        cfg_wr;
    logic [1:0]  cfg_addr;
    logic [7:0]  cfg_wdata;
    logic        atm_valid;
    logic [23:0] atm_light;
    logic        proc_bypass;
    logic [7:0]  proc_omega;
    logic [7:0]  proc_t0;
    logic [23:0] proc_atm;
    logic        frame_start, frame_done, geom_err;
    logic [15:0] frame_cnt;

    haze_frame_ctrl #(
        .PIC_WIDTH     (W),
        .PIC_HEIGHT    (H),
        .WARMUP_FRAMES (WARMUP),
        .ATM_TIMEOUT   (ATM_T),
        .ATM_DEFAULT   (ATM_D)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pre_frame_vsync (vsync),
        .pre_frame_href  (href),
        .pre_frame_clken (clken),
        .cfg_wr          (cfg_wr),
        .cfg_addr        (cfg_addr),
        .cfg_wdata       (cfg_wdata),
        .atm_valid       (atm_valid),
        .atm_light       (atm_light),
        .proc_bypass     (proc_bypass),
        .proc_omega      (proc_omega),
        .proc_t0         (proc_t0),
        .proc_atm        (proc_atm),
        .frame_start     (frame_start),
        .frame_done      (frame_done),
        .geom_err        (geom_err),
        .frame_cnt       (frame_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Bench view of the shadow registers (what software has written)
    logic        m_sh_bypass;
    logic [7:0]  m_sh_omega, m_sh_t0;
    // Scheduled events: cycle numbers at which outputs must change
    int          next_fs, next_fd, next_atm;
    logic        pend_sh_bypass, pend_geom;
    logic [7:0]  pend_omega, pend_t0;
    logic [23:0] pend_atm;
    int          lines_sent;
    logic        bad_line;
    // Expected steady outputs (owned by the checker)
    logic        exp_bypass = 1'b1, exp_geom = 1'b0;
    logic [7:0]  exp_omega = 8'd243, exp_t0 = 8'd26;
    logic [23:0] exp_atm = ATM_D;
    int          exp_cnt = 0;

    task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    function automatic logic [23:0] atm_model(input logic [23:0] old_v, input logic [23:0] new_v);
        logic [23:0] r;
`ifdef HAZE_ATM_IIR_EN
        for (int c = 0; c < 3; c++) begin
            int o, n;
            o = int'(old_v[c*8 +: 8]);
            n = int'(new_v[c*8 +: 8]);
            r[c*8 +: 8] = 8'((3 * o + n) / 4);
        end
`else
        r = new_v;
        if (old_v == 24'h0) r = new_v;
`endif
        return r;
    endfunction

    // Per-cycle compare against the frame-level model
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (rst) begin
            exp_bypass = 1'b1;
            exp_omega  = 8'd243;
            exp_t0     = 8'd26;
            exp_atm    = ATM_D;
            exp_geom   = 1'b0;
            exp_cnt    = 0;
        end else begin
            if (cyc == next_fs) begin
                exp_bypass = pend_sh_bypass || (exp_cnt < WARMUP);
                exp_omega  = pend_omega;
                exp_t0     = pend_t0;
            end
            if (cyc == next_fd) begin
                exp_geom = pend_geom;
                if (exp_cnt < 65535) exp_cnt = exp_cnt + 1;
            end
            if (cyc == next_atm) exp_atm = pend_atm;
        end
        check("frame_start", 24'(frame_start), 24'(!rst && cyc == next_fs));
        check("frame_done",  24'(frame_done),  24'(!rst && cyc == next_fd));
        check("proc_bypass", 24'(proc_bypass), 24'(exp_bypass));
        check("proc_omega",  24'(proc_omega),  24'(exp_omega));
        check("proc_t0",     24'(proc_t0),     24'(exp_t0));
        check("proc_atm",    proc_atm,         exp_atm);
        check("geom_err",    24'(geom_err),    24'(exp_geom));
        check("frame_cnt",   24'(frame_cnt),   24'(exp_cnt));
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        m_sh_bypass = 1'b0;
        m_sh_omega  = 8'd243;
        m_sh_t0     = 8'd26;
        next_fs     = -1;
        next_fd     = -1;
        next_atm    = -1;
    endtask

    // Raise vsync now; the copy and frame_start appear on the next edge
    task automatic start_frame();
        vsync          = 1'b1;
        pend_sh_bypass = m_sh_bypass;
        pend_omega     = m_sh_omega;
        pend_t0        = m_sh_t0;
        next_fs        = cyc + 1;
        lines_sent     = 0;
        bad_line       = 1'b0;
    endtask

    task automatic end_frame();
        vsync     = 1'b0;
        pend_geom = bad_line || (lines_sent != H);
        next_fd   = cyc + 1;
    endtask

    // One line of npix enabled pixels with a clken stall before pixel 3
    task automatic send_line(input int npix);
        href = 1'b1;
        for (int p = 0; p < npix; p++) begin
            if (p == 3) begin
                clken = 1'b0;
                step(1);
            end
            clken = 1'b1;
            step(1);
        end
        href  = 1'b0;
        clken = 1'b0;
        step(2);
        lines_sent++;
        if (npix != W) bad_line = 1'b1;
    endtask

    task automatic cfg_set(input logic [1:0] a, input logic [7:0] d);
        cfg_wr    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        case (a)
            2'd0:    m_sh_bypass = d[0];
            2'd1:    m_sh_omega  = d;
            2'd2:    m_sh_t0     = d;
            default: ;
        endcase
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        cfg_set(a, d);
        step(1);
        cfg_wr = 1'b0;
    endtask

    task automatic atm_pulse(input logic [23:0] v, input bit accept);
        atm_valid = 1'b1;
        atm_light = v;
        if (accept) begin
            pend_atm = atm_model(exp_atm, v);
            next_atm = cyc + 1;
        end
        step(1);
        atm_valid = 1'b0;
    endtask

    task automatic clean_lines();
        for (int l = 0; l < H; l++) send_line(W);
    endtask

    logic [23:0] atm_after_f1;

    initial begin
`ifdef HAZE_ATM_IIR_EN
        atm_after_f1 = 24'hC4C4C4;
`else
        atm_after_f1 = 24'h404040;
`endif
        rst = 1'b1; vsync = 1'b0; href = 1'b0; clken = 1'b0;
        cfg_wr = 1'b0; cfg_addr = 2'd0; cfg_wdata = 8'd0;
        atm_valid = 1'b0; atm_light = 24'd0;
        model_reset();
        step(3);
        rst = 1'b0;
        step(2);
        check("rst_bypass", 24'(proc_bypass), 24'h1);
        check("rst_omega",  24'(proc_omega),  24'hF3);
        check("rst_t0",     24'(proc_t0),     24'h1A);
        check("rst_atm",    proc_atm,         24'hF0F0F0);
        check("rst_cnt",    24'(frame_cnt),   24'h0);

        // Frame 1: clean, warm-up bypass, atm accepted 5 cycles after end
        start_frame(); step(2);
        check("f1_bypass", 24'(proc_bypass), 24'h1);
        clean_lines();
        end_frame(); step(5);
        atm_pulse(24'h404040, 1'b1); step(2);
        check("f1_atm", proc_atm, atm_after_f1);

        // Frame 2: clean, bypass released; then let the atm wait time out
        start_frame(); step(2);
        check("f2_bypass", 24'(proc_bypass), 24'h0);
        clean_lines();
        end_frame(); step(2);
        check("f2_cnt",  24'(frame_cnt), 24'h2);
        check("f2_geom", 24'(geom_err),  24'h0);
        step(ATM_T + 2);
        atm_pulse(24'h101010, 1'b0); step(2);
        check("timeout_atm", proc_atm, atm_after_f1);

        // Frame 3: short second line, mid-frame omega write, stray atm_valid
        start_frame(); step(2);
        send_line(W);
        cfg_write(2'd1, 8'h80);
        atm_pulse(24'h000000, 1'b0);
        check("f3_omega_mid", 24'(proc_omega), 24'hF3);
        send_line(W - 1);
        send_line(W);
        send_line(W);
        end_frame(); step(2);
        check("f3_geom",  24'(geom_err),   24'h1);
        check("f3_omega", 24'(proc_omega), 24'hF3);
        step(ATM_T + 4);

        // Frame 4: clean, new omega active, error cleared
        start_frame(); step(2);
        check("f4_omega", 24'(proc_omega), 24'h80);
        clean_lines();
        end_frame(); step(2);
        check("f4_geom", 24'(geom_err), 24'h0);
        step(1);

        // Frame 5 starts out of UPDATE with coincident atm_valid and t0 write
        start_frame();
        atm_valid = 1'b1;
        atm_light = 24'h000000;
        cfg_set(2'd2, 8'h33);
        step(1);
        atm_valid = 1'b0;
        cfg_wr    = 1'b0;
        step(1);
        check("f5_t0",  24'(proc_t0), 24'h1A);
        check("f5_atm", proc_atm,     atm_after_f1);
        send_line(W);
        cfg_write(2'd3, 8'h55);
        send_line(W); send_line(W); send_line(W);
        end_frame(); step(ATM_T + 4);

        // Frame 6: t0 from coincident write, then reset mid-frame
        start_frame(); step(2);
        check("f6_t0", 24'(proc_t0), 24'h33);
        send_line(W); send_line(W);
        rst = 1'b1;
        model_reset();
        step(2);
        rst = 1'b0;
        step(2);
        check("rst2_omega", 24'(proc_omega), 24'hF3);
        check("rst2_t0",    24'(proc_t0),    24'h1A);
        check("rst2_cnt",   24'(frame_cnt),  24'h0);
        send_line(W);
        step(3);
        vsync = 1'b0;
        step(3);
        send_line(W);

        // Frame 7: fresh start after reset, warm-up again, bypass write
        start_frame(); step(2);
        check("f7_bypass", 24'(proc_bypass), 24'h1);
        send_line(W); send_line(W);
        cfg_write(2'd0, 8'h01);
        send_line(W); send_line(W);
        end_frame(); step(2);
        check("f7_cnt", 24'(frame_cnt), 24'h1);
        step(ATM_T + 4);

        // Frame 8: shadow bypass forces bypass after warm-up
        start_frame(); step(2);
        check("f8_bypass", 24'(proc_bypass), 24'h1);
        clean_lines();
        end_frame(); step(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
        $fatal(1, "watchdog");
    end

endmodule : tb_haze_frame_ctrl
`default_nettype wire
